// File: rtl/register_file_pkg.sv
// Shared types and default sizing for the register file and its clear sequencer.
package register_file_pkg;

  typedef enum logic {
    ST_CLEARING = 1'b0,
    ST_IDLE     = 1'b1
  } clear_state_e;

  localparam int DEFAULT_DATA_WIDTH    = 32;
  localparam int DEFAULT_ADDR_WIDTH    = 5;
  localparam int DEFAULT_ZERO_REGISTER = 1;

endpackage

// File: rtl/register_file_clear_ctrl.sv
// Clear sequencer: walks clear_index over every entry after reset or a clear request,
// then holds IDLE with ready high until the next clear.
module register_file_clear_ctrl
  import register_file_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
)(
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear_request,
  output logic [ADDR_WIDTH-1:0] clear_index,
  output logic                  ready
);

  localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] INDEX_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  clear_state_e          state_r;
  logic [ADDR_WIDTH-1:0] clear_index_r;
  logic                  ready_r;

  // Sequencer state, sweep index and registered ready flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_CLEARING;
      clear_index_r <= {ADDR_WIDTH{1'b0}};
      ready_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_CLEARING: begin
          // Requests during a sweep are ignored; the sweep always runs to completion.
          if (clear_index_r == LAST_INDEX) begin
            state_r       <= ST_IDLE;
            clear_index_r <= {ADDR_WIDTH{1'b0}};
            ready_r       <= 1'b1;
          end else begin
            clear_index_r <= clear_index_r + INDEX_ONE;
          end
        end
        ST_IDLE: begin
          if (clear_request) begin
            state_r       <= ST_CLEARING;
            clear_index_r <= {ADDR_WIDTH{1'b0}};
            ready_r       <= 1'b0;
          end else begin
            ready_r       <= 1'b1;
          end
        end
        default: begin
          state_r       <= ST_CLEARING;
          clear_index_r <= {ADDR_WIDTH{1'b0}};
          ready_r       <= 1'b0;
        end
      endcase
    end
  end

  assign clear_index = clear_index_r;
  assign ready       = ready_r;

endmodule

// File: rtl/register_file.sv
// Two-read / two-write register file that zeroes itself after reset or clear_request.
// Define REGISTER_FILE_BYPASS_EN to forward same-cycle write data to matching reads.
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH    = DEFAULT_ADDR_WIDTH,
  parameter int ZERO_REGISTER = DEFAULT_ZERO_REGISTER
)(
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  write_enabled_a,
  input  logic                  write_enabled_b,
  input  logic [ADDR_WIDTH-1:0] register_destiny_a,
  input  logic [ADDR_WIDTH-1:0] register_destiny_b,
  input  logic [DATA_WIDTH-1:0] write_data_a,
  input  logic [DATA_WIDTH-1:0] write_data_b,
  input  logic [ADDR_WIDTH-1:0] register_source1,
  input  logic [ADDR_WIDTH-1:0] register_source2,
  output logic [DATA_WIDTH-1:0] register_base_out1,
  output logic [DATA_WIDTH-1:0] register_base_out2,
  input  logic                  clear_request,
  output logic                  ready
);

  localparam int                    DEPTH     = 2 ** ADDR_WIDTH;
  localparam bit                    ZERO_EN   = (ZERO_REGISTER != 0);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};

  logic                  ready_s;
  logic [ADDR_WIDTH-1:0] clear_index_s;
  logic                  write_a_s;
  logic                  write_b_s;
  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] read1_s;
  logic [DATA_WIDTH-1:0] read2_s;

  register_file_clear_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clear_ctrl (
    .clock         (clock),
    .reset_n       (reset_n),
    .clear_request (clear_request),
    .clear_index   (clear_index_s),
    .ready         (ready_s)
  );

  // A write commits only in IDLE, not in the cycle that requests a clear, and never to a hardwired r0.
  assign write_a_s = ready_s && !clear_request && write_enabled_a &&
                     !(ZERO_EN && (register_destiny_a == ADDR_ZERO));
  assign write_b_s = ready_s && !clear_request && write_enabled_b &&
                     !(ZERO_EN && (register_destiny_b == ADDR_ZERO));

  // Storage update: sweep zeroes while clearing, otherwise port writes with B issued last so it wins.
  always_ff @(posedge clock) begin
    if (!ready_s) begin
      mem_r[clear_index_s] <= {DATA_WIDTH{1'b0}};
    end else begin
      if (write_a_s) begin
        mem_r[register_destiny_a] <= write_data_a;
      end
      if (write_b_s) begin
        mem_r[register_destiny_b] <= write_data_b;
      end
    end
  end

  function automatic logic [DATA_WIDTH-1:0] read_entry(input logic [ADDR_WIDTH-1:0] addr);
    logic [DATA_WIDTH-1:0] value;
    if (!ready_s || (ZERO_EN && (addr == ADDR_ZERO))) begin
      value = {DATA_WIDTH{1'b0}};
`ifdef REGISTER_FILE_BYPASS_EN
    end else if (write_b_s && (register_destiny_b == addr)) begin
      value = write_data_b;
    end else if (write_a_s && (register_destiny_a == addr)) begin
      value = write_data_a;
`endif
    end else begin
      value = mem_r[addr];
    end
    return value;
  endfunction

  // Zero-latency read ports.
  always_comb begin
    read1_s = {DATA_WIDTH{1'b0}};
    read2_s = {DATA_WIDTH{1'b0}};
    read1_s = read_entry(register_source1);
    read2_s = read_entry(register_source2);
  end

  assign register_base_out1 = read1_s;
  assign register_base_out2 = read2_s;
  assign ready              = ready_s;

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus queues expected values, a negedge monitor checks them.
module tb_register_file;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clock;
  logic          reset_n;
  logic          we_a;
  logic          we_b;
  logic [AW-1:0] dst_a;
  logic [AW-1:0] dst_b;
  logic [DW-1:0] wd_a;
  logic [DW-1:0] wd_b;
  logic [AW-1:0] src1;
  logic [AW-1:0] src2;
  logic [DW-1:0] out1;
  logic [DW-1:0] out2;
  logic          clear_request;
  logic          ready;

  typedef struct {
    string         name;
    int            sel;
    logic [DW-1:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  register_file #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .ZERO_REGISTER (1)
  ) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .write_enabled_a    (we_a),
    .write_enabled_b    (we_b),
    .register_destiny_a (dst_a),
    .register_destiny_b (dst_b),
    .write_data_a       (wd_a),
    .write_data_b       (wd_b),
    .register_source1   (src1),
    .register_source2   (src2),
    .register_base_out1 (out1),
    .register_base_out2 (out2),
    .clear_request      (clear_request),
    .ready              (ready)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Monitor: drain every queued expectation against the outputs the DUT presents at the negedge.
  initial begin
    exp_t          item;
    logic [DW-1:0] act;
    forever begin
      @(negedge clock);
      while (exp_q.size() > 0) begin
        item = exp_q.pop_front();
        case (item.sel)
          0:       act = {31'd0, ready};
          1:       act = out1;
          default: act = out2;
        endcase
        tests_run++;
        if (act !== item.exp) begin
          tests_failed++;
          $display("FAIL %s: got 0x%08h, expected 0x%08h", item.name, act, item.exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_out(input string name, input int sel, input logic [DW-1:0] value);
    exp_t item;
    item.name = name;
    item.sel  = sel;
    item.exp  = value;
    exp_q.push_back(item);
  endtask

  task automatic check_now(input string name, input logic [DW-1:0] act, input logic [DW-1:0] value);
    tests_run++;
    if (act !== value) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, value);
    end
  endtask

  // Expects ready low for DEPTH-1 edges and high after edge DEPTH; optionally re-requests a clear mid-sweep.
  task automatic expect_clear(input string name, input int retrigger_at);
    for (int k = 1; k <= DEPTH; k++) begin
      tick();
      clear_request = (k == retrigger_at);
      we_a          = (k == retrigger_at);
      dst_a         = 5'd12;
      wd_a          = 32'h0000_1212;
      expect_out(name, 0, (k == DEPTH) ? 32'd1 : 32'd0);
    end
    clear_request = 1'b0;
    we_a          = 1'b0;
    check_now({name, "_expired"}, {31'd0, ready}, 32'd1);
  endtask

  initial begin
    reset_n = 1'b0; we_a = 1'b0; we_b = 1'b0; clear_request = 1'b0;
    dst_a = 5'd0; dst_b = 5'd0; wd_a = 32'd0; wd_b = 32'd0; src1 = 5'd5; src2 = 5'd9;

    // Reset held: ready low, reads zero.
    tick();
    check_now("reset_state_ready", {31'd0, ready}, 32'd0);
    check_now("reset_state_out1", out1, 32'd0);
    check_now("reset_state_out2", out2, 32'd0);
    expect_out("reset_ready", 0, 32'd0);
    expect_out("reset_out1", 1, 32'd0);
    expect_out("reset_out2", 2, 32'd0);
    tick();
    reset_n = 1'b1;
    expect_clear("init_clear_ready", 0);

    // Every entry reads zero after the initial sweep.
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      src1 = AW'(i);
      src2 = AW'(DEPTH - 1 - i);
      expect_out("init_zero_out1", 1, 32'd0);
      expect_out("init_zero_out2", 2, 32'd0);
    end

    // Port A to r5, port B to hardwired r0.
    tick();
    we_a = 1'b1; dst_a = 5'd5; wd_a = 32'hDEAD_BEEF;
    we_b = 1'b1; dst_b = 5'd0; wd_b = 32'h1234_5678;
    src1 = 5'd1; src2 = 5'd0;
    expect_out("r0_bypass_blocked", 2, 32'd0);
    tick();
    we_a = 1'b0; we_b = 1'b0; src1 = 5'd5; src2 = 5'd0;
    expect_out("r5_write", 1, 32'hDEAD_BEEF);
    expect_out("r0_write_dropped", 2, 32'd0);

    // Same-address collision: port B wins.
    tick();
    we_a = 1'b1; dst_a = 5'd7; wd_a = 32'h1111_1111;
    we_b = 1'b1; dst_b = 5'd7; wd_b = 32'h2222_2222;
    tick();
    we_a = 1'b0; we_b = 1'b0; src1 = 5'd7;
    expect_out("r7_port_b_wins", 1, 32'h2222_2222);

    // Same-cycle read of an address being written.
    tick();
    we_a = 1'b1; dst_a = 5'd9; wd_a = 32'hAAAA_0000;
    tick();
    we_a = 1'b1; dst_a = 5'd9; wd_a = 32'h5555_FFFF; src2 = 5'd9;
`ifdef REGISTER_FILE_BYPASS_EN
    expect_out("r9_same_cycle", 2, 32'h5555_FFFF);
`else
    expect_out("r9_same_cycle", 2, 32'hAAAA_0000);
`endif
    tick();
    we_a = 1'b0;
    expect_out("r9_after", 2, 32'h5555_FFFF);

    // Clear request with a simultaneous write to r4 (dropped), plus an ignored re-request mid-sweep.
    tick();
    we_a = 1'b1; dst_a = 5'd3; wd_a = 32'hCAFE_F00D;
    tick();
    we_a = 1'b0; clear_request = 1'b1;
    we_b = 1'b1; dst_b = 5'd4; wd_b = 32'h0BAD_F00D;
    src1 = 5'd3; src2 = 5'd4;
    expect_out("clr_req_ready", 0, 32'd1);
    expect_out("clr_req_r3", 1, 32'hCAFE_F00D);
    expect_out("clr_req_r4", 2, 32'd0);
    tick();
    clear_request = 1'b0; we_b = 1'b0;
    expect_out("clearing_out1_zero", 1, 32'd0);
    expect_out("clearing_ready", 0, 32'd0);
    expect_clear("clear_ready", 10);
    tick();
    expect_out("cleared_r3", 1, 32'd0);
    expect_out("cleared_r4", 2, 32'd0);

    // Reset asserted mid-write in IDLE: outputs drop at once, sweep restarts on release.
    tick();
    we_a = 1'b1; dst_a = 5'd6; wd_a = 32'h0000_600D;
    src1 = 5'd6; src2 = 5'd7;
    tick();
    we_a = 1'b0;
    expect_out("r6_written", 1, 32'h0000_600D);
    tick();
    we_a = 1'b1; dst_a = 5'd8; wd_a = 32'h0000_0088;
    reset_n = 1'b0;
    expect_out("rst_idle_ready", 0, 32'd0);
    expect_out("rst_idle_out1", 1, 32'd0);
    expect_out("rst_idle_out2", 2, 32'd0);
    tick();
    we_a = 1'b0; reset_n = 1'b1;

    // Reset again at clear_index 10, then a full restart.
    for (int k = 1; k <= 10; k++) begin
      tick();
      expect_out("pre_midreset_ready", 0, 32'd0);
    end
    reset_n = 1'b0;
    expect_out("midreset_ready", 0, 32'd0);
    expect_out("midreset_out1", 1, 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    expect_clear("restart_clear_ready", 0);
    tick();
    expect_out("restart_r6", 1, 32'd0);
    expect_out("restart_r7", 2, 32'd0);

    tick();
    @(negedge clock);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register data width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5; depth = 2**ADDR_WIDTH entries.
REQ-003 SHALL have parameter ZERO_REGISTER, default 1; 1 = entry 0 hardwired to zero.
REQ-004 SHALL have port clock  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports write_enabled_a / write_enabled_b  input  1  write strobe per write port.
REQ-007 SHALL have ports register_destiny_a / register_destiny_b  input  ADDR_WIDTH  write address per port.
REQ-008 SHALL have ports write_data_a / write_data_b  input  DATA_WIDTH  write data per port.
REQ-009 SHALL have ports register_source1 / register_source2  input  ADDR_WIDTH  read addresses.
REQ-010 SHALL have ports register_base_out1 / register_base_out2  output  DATA_WIDTH  combinational read data.
REQ-011 SHALL have port clear_request  input  1  single-cycle request to re-zero all entries.
REQ-012 SHALL have port ready  output  1  high when the file accepts writes and returns stored data.

Function
REQ-013 SHALL implement FSM states CLEARING and IDLE.
REQ-014 In CLEARING, SHALL write zero to entry clear_index each cycle, incrementing clear_index from 0 to 2**ADDR_WIDTH-1, then enter IDLE; clear takes exactly 2**ADDR_WIDTH cycles.
REQ-015 In CLEARING, SHALL ignore both write ports, hold ready=0, and drive both read outputs to zero.
REQ-016 In IDLE, clear_request=1 SHALL enter CLEARING with clear_index=0 on the next edge; writes in that same cycle SHALL be discarded.
REQ-017 clear_request while already CLEARING SHALL be ignored (no restart).
REQ-018 In IDLE, write_enabled_x=1 SHALL store write_data_x at register_destiny_x on the rising edge; written value visible on reads the following cycle.
REQ-019 Both ports writing the same address in one cycle SHALL store port B data; port A write is dropped.
REQ-020 With ZERO_REGISTER=1, writes to address 0 SHALL be discarded and reads of address 0 SHALL return zero in every state.
REQ-021 Reads SHALL be combinational, zero latency, and any two read/write addresses may coincide.
REQ-022 ready SHALL be 1 exactly when state is IDLE.

Reset
REQ-023 reset_n=0 SHALL immediately force state CLEARING, clear_index=0, ready=0, read outputs zero, independent of clock.
REQ-024 Storage array SHALL not be reset directly; it is zeroed by the clear sequence after reset_n rises.
REQ-025 reset_n asserted mid-clear or mid-write SHALL restart the clear sequence from index 0 on release.

Configuration
REQ-026 With macro REGISTER_FILE_BYPASS_EN defined, a read address matching an enabled same-cycle IDLE write SHALL return that write data (port B over port A), excluding address 0 when ZERO_REGISTER=1.
REQ-027 Without REGISTER_FILE_BYPASS_EN, reads SHALL return the stored pre-edge value; no bypass logic SHALL be generated.

Structure
REQ-028 FSM state encoding (CLEARING, IDLE) and default width constants SHALL live in shared package register_file_pkg.
REQ-029 Clear sequencer (state, clear_index, ready) SHALL be sub-module register_file_clear_ctrl; storage, write arbitration and bypass stay in register_file.

Verification
REQ-030 Reset release, defaults -> ready=0 for exactly 32 cycles, then ready=1; all 32 entries read 0x00000000.
REQ-031 IDLE, port A writes 0xDEADBEEF to r5 -> register_base_out1 with source1=5 reads 0xDEADBEEF next cycle; r0 write of 0x12345678 -> r0 reads 0.
REQ-032 Both ports write r7 (A=0x11111111, B=0x22222222) -> r7 reads 0x22222222.
REQ-033 r9=0xAAAA0000, same-cycle write 0x5555FFFF to r9 with source2=9 -> out2=0x5555FFFF with REGISTER_FILE_BYPASS_EN, 0xAAAA0000 without.
REQ-034 clear_request pulse with r3=0xCAFEF00D and simultaneous write to r4 -> ready low 32 cycles, then r3=0, r4=0.
REQ-035 reset_n pulsed low at clear_index=10 -> outputs zero immediately; full 32-cycle clear restarts from index 0.
